full_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 19 +
 rtl/full_adder_cell.sv | 19 +
 rtl/full_adder.sv | 67 ++++++
 tb/tb_full_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder: width limit and per-bit result type.
`timescale 1ns/1ps
package adder_pkg;

    localparam int unsigned ADDER_MAX_WIDTH = 64;

    typedef struct packed {
        logic s;
        logic co;
    } fa_bit_t;

    function automatic fa_bit_t fa_eval(input logic a, input logic b, input logic ci);
        fa_bit_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell; gate-level form keeps X confined to the affected bit.
`timescale 1ns/1ps
module full_adder_cell
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    fa_bit_t res;

    assign res = fa_eval(a, b, ci);
    assign s   = res.s;
    assign co  = res.co;

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry full adder with optional registered result.
// Register stage is built only when FULL_ADDER_REG_OUT_EN is defined.
`timescale 1ns/1ps
module full_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic             in_vld,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_vld
);

    generate
        if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
            $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
        end
    endgenerate

    // carry chain: k[0] is the carry-in, k[WIDTH] the carry-out
    logic [WIDTH:0] k;

    assign k[0] = c;
    assign cout = k[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (k[i]),
            .s  (sum[i]),
            .co (k[i+1])
        );
    end

`ifdef FULL_ADDER_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                sum_q  <= sum;
                cout_q <= cout;
            end
        end
    end
`else
    logic unused_ok;

    assign sum_q     = '0;
    assign cout_q    = 1'b0;
    assign out_vld   = 1'b0;
    assign unused_ok = &{1'b0, clk, rst_n, in_vld};
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: WIDTH=1 and WIDTH=8 instances, comb and registered paths.
`timescale 1ns/1ps
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a1, b1, c1, in_vld1;
    logic       s1, co1, sq1, cq1, ov1;

    logic [7:0] a8, b8, s8, sq8;
    logic       c8, co8, cq8, ov8, in_vld8;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit         narrow;
        logic [8:0] exp;
        string      name;
    } comb_exp_t;

    typedef struct {
        logic       vld;
        logic [7:0] s;
        logic       co;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];
    event      comb_ev;

    logic [7:0] pv_s;
    logic       pv_co;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1),
        .sum(s1), .cout(co1), .in_vld(in_vld1),
        .sum_q(sq1), .cout_q(cq1), .out_vld(ov1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8),
        .sum(s8), .cout(co8), .in_vld(in_vld8),
        .sum_q(sq8), .cout_q(cq8), .out_vld(ov8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference: plain integer addition, result is {carry, sum}
    function automatic logic [8:0] ref_add(input int unsigned x, input int unsigned y, input int unsigned ci);
        int unsigned t;
        t = x + y + ci;
        return t[8:0];
    endfunction

    task automatic comb_w1(input logic [2:0] abc);
        {a1, b1, c1} = abc;
        comb_q.push_back('{1'b1, ref_add(abc[2], abc[1], abc[0]), "w1_comb"});
        #1 -> comb_ev;
        #9;
    endtask

    task automatic comb_w8(input logic [7:0] x, input logic [7:0] y, input logic ci, input string nm);
        a8 = x; b8 = y; c8 = ci;
        comb_q.push_back('{1'b0, ref_add(x, y, ci), nm});
        #1 -> comb_ev;
        #1;
    endtask

    // drive one registered cycle at negedge and record the expected state after the next posedge
    task automatic reg_cycle(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic v);
        logic [8:0] r;
        @(negedge clk);
        a8 = x; b8 = y; c8 = ci; in_vld8 = v;
        r = ref_add(x, y, ci);
`ifdef FULL_ADDER_REG_OUT_EN
        if (v) begin
            pv_s  = r[7:0];
            pv_co = r[8];
        end
        reg_q.push_back('{v, pv_s, pv_co});
`else
        reg_q.push_back('{1'b0, 8'h00, 1'b0});
`endif
    endtask

    // comb monitor
    initial begin
        comb_exp_t e;
        forever begin
            @(comb_ev);
            if (comb_q.size() == 0) begin
                check("comb_queue_underflow", 64'd1, 64'd0);
            end else begin
                e = comb_q.pop_front();
                if (e.narrow) check(e.name, {62'd0, co1, s1}, {55'd0, e.exp});
                else          check(e.name, {55'd0, co8, s8}, {55'd0, e.exp});
            end
        end
    end

    // registered-output monitor
    initial begin
        reg_exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (reg_q.size() != 0) begin
                e = reg_q.pop_front();
                check("out_vld", {63'd0, ov8}, {63'd0, e.vld});
                check("sum_q",   {56'd0, sq8}, {56'd0, e.s});
                check("cout_q",  {63'd0, cq8}, {63'd0, e.co});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x, y;
        logic       ci, v;

        rst_n = 1'b0;
        {a1, b1, c1, in_vld1} = '0;
        a8 = '0; b8 = '0; c8 = 1'b0; in_vld8 = 1'b0;
        pv_s = '0; pv_co = 1'b0;

        #2;
        check("rst_sum_q8",   {56'd0, sq8}, 64'd0);
        check("rst_cout_q8",  {63'd0, cq8}, 64'd0);
        check("rst_out_vld8", {63'd0, ov8}, 64'd0);
        check("rst_sum_q1",   {63'd0, sq1}, 64'd0);
        check("rst_out_vld1", {63'd0, ov1}, 64'd0);

        // WIDTH=1 truth table, exercised while still in reset
        for (int unsigned i = 0; i < 8; i++) comb_w1(i[2:0]);

        @(negedge clk);
        rst_n = 1'b1;

        comb_w8(8'hFF, 8'h00, 1'b1, "wrap_ff_00_1");
        comb_w8(8'h5A, 8'hA5, 1'b0, "5a_a5_0");
        comb_w8(8'hFF, 8'hFF, 1'b1, "ones_ones_1");
        comb_w8(8'h00, 8'h00, 1'b0, "zeros_0");
        comb_w8(8'h00, 8'h00, 1'b1, "zeros_1");

        for (int unsigned i = 0; i < 10000; i++)
            comb_w8(8'($urandom), 8'($urandom), 1'($urandom), "rand_comb");

        // registered path: capture, then hold with inputs changing
        reg_cycle(8'h80, 8'h80, 1'b1, 1'b1);
        reg_cycle(8'h33, 8'h11, 1'b0, 1'b0);
        reg_cycle(8'hC3, 8'h5E, 1'b1, 1'b0);

        for (int unsigned i = 0; i < 300; i++) begin
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); v = 1'($urandom);
            reg_cycle(x, y, ci, v);
        end
        repeat (2) @(posedge clk);
        #3;

        // reset pulse between edges drops the in-flight capture
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; in_vld8 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rstpulse_sum_q",   {56'd0, sq8}, 64'd0);
        check("rstpulse_cout_q",  {63'd0, cq8}, 64'd0);
        check("rstpulse_out_vld", {63'd0, ov8}, 64'd0);
        check("rstpulse_comb",    {55'd0, co8, s8}, {55'd0, ref_add(8'h7F, 8'h01, 1'b0)});
        in_vld8 = 1'b0;
        rst_n   = 1'b1;
        pv_s = '0; pv_co = 1'b0;
        reg_q.push_back('{1'b0, 8'h00, 1'b0});

        for (int unsigned i = 0; i < 50; i++) begin
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); v = 1'($urandom);
            reg_cycle(x, y, ci, v);
        end
        repeat (2) @(posedge clk);
        #3;

        check("comb_queue_drained", 64'(comb_q.size()), 64'd0);
        check("reg_queue_drained",  64'(reg_q.size()),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
